// File: rtl/dm_lsu_pkg.sv
// Shared encodings and helpers for the data-memory load/store unit.
package dm_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_MERGE,
    ST_RESP
  } state_e;

  // True for requests that must be rejected without touching memory.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lsu_lane.sv
// Byte-lane logic: extract/extend a load lane, or merge store data into a read word.
module dm_lsu_lane
  import dm_lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        signed_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b  = word_i[8*off_i +: 8];
    lane_h  = off_i[1] ? word_i[31:16] : word_i[15:0];
    load_o  = word_i;
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_o                = {{24{signed_i & lane_b[7]}}, lane_b};
        merge_o[8*off_i +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o = {{16{signed_i & lane_h[15]}}, lane_h};
        if (off_i[1]) merge_o[31:16] = wdata_i;
        else          merge_o[15:0]  = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit driving a word-wide data memory without byte enables.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state_q, state_d;

  logic              we_q, signed_q, err_q;
  logic [1:0]        size_q, off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  logic              accept, fault, word_store;
  logic [DATA_W-1:0] lane_load, lane_merge;
  logic              unused_addr_hi;

  assign accept         = req_valid && (state_q == ST_IDLE);
  assign fault          = is_misaligned(req_size, req_addr[1:0]);
  assign word_store     = we_q && (size_q == SZ_WORD);
  assign unused_addr_hi = ^req_addr[DATA_W-1:ADDR_W+2];

  dm_lsu_lane u_lane (
    .word_i   (mem_rdata),
    .size_i   (size_q),
    .off_i    (off_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q[15:0]),
    .load_o   (lane_load),
    .merge_o  (lane_merge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        err_q    <= fault;
        size_q   <= req_size;
        off_q    <= req_addr[1:0];
        addr_q   <= req_addr[ADDR_W+1:2];
        wdata_q  <= req_wdata;
      end
      // Load data is sticky across stores; only a fault or a new load changes it.
      if (accept && fault) begin
        rdata_q <= '0;
      end else if (state_q == ST_CAPTURE) begin
        rdata_q <= lane_load;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = fault ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (word_store) begin
          mem_wr    = 1'b1;
          mem_wdata = wdata_q;
          state_d   = ST_RESP;
        end else begin
          mem_rd  = 1'b1;
          state_d = we_q ? ST_MERGE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: state_d = ST_RESP;
      ST_MERGE: begin
        mem_wr    = 1'b1;
        mem_wdata = lane_merge;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: transaction-timeline reference model, per-cycle compare, directed and random requests.
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [6:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  dm_lsu #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Data memory: 128 words, registered read.
  logic [31:0] dmem [128];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= dmem[mem_addr];
    if (mem_wr) dmem[mem_addr] <= mem_wdata;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out, got no event expected one (cycle %0d)", nm, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic int latency_of(input logic we, input logic [1:0] sz, input logic [31:0] a);
    if (is_fault(sz, a)) return 1;
    if (we && sz == 2'd2) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic sg, input logic [1:0] off);
    int unsigned bits;
    logic [31:0] mask, v;
    if (sz == 2'd2) return w;
    bits = (sz == 2'd0) ? 8 : 16;
    mask = (32'h1 << bits) - 32'h1;
    v = (w >> (8 * off)) & mask;
    if (sg && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] f_store(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] off, input logic [31:0] d);
    logic [31:0] mask;
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
    return (w & ~mask) | ((d << (8 * off)) & mask);
  endfunction

  logic [31:0] ref_mem [128];
  int          phase = 0;     // 0 idle, k = k-th cycle after acceptance
  int          lat = 1;
  int          acc_cnt = 0;
  logic        m_we = 1'b0, m_sg = 1'b0, m_fault = 1'b0;
  logic [1:0]  m_sz = 2'b00;
  logic [31:0] m_addr = '0, m_wd = '0;
  logic [31:0] exp_rdata = '0;
  logic [6:0]  m_idx;
  logic        m_ws;

  assign m_idx = m_addr[8:2];
  assign m_ws  = m_we && (m_sz == 2'd2);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 0;
      exp_rdata <= '0;
    end else if (phase == 0) begin
      if (req_valid) begin
        m_we    <= req_we;
        m_sz    <= req_size;
        m_sg    <= req_signed;
        m_addr  <= req_addr;
        m_wd    <= req_wdata;
        m_fault <= is_fault(req_size, req_addr);
        lat     <= latency_of(req_we, req_size, req_addr);
        acc_cnt <= acc_cnt + 1;
        phase   <= 1;
        if (is_fault(req_size, req_addr)) exp_rdata <= '0;
      end
    end else begin
      if (!m_fault && m_we && phase == (m_ws ? 1 : 2))
        ref_mem[m_idx] <= m_ws ? m_wd : f_store(ref_mem[m_idx], m_sz, m_addr[1:0], m_wd);
      if (!m_fault && !m_we && phase == 2)
        exp_rdata <= f_load(ref_mem[m_idx], m_sz, m_sg, m_addr[1:0]);
      phase <= (phase == lat) ? 0 : phase + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic e_rd, e_wr, e_valid;
    e_rd    = (phase == 1) && !m_fault && !m_ws;
    e_wr    = (phase != 0) && !m_fault && m_we && (phase == (m_ws ? 1 : 2));
    e_valid = (phase != 0) && (phase == lat);
    chk("req_ready", 32'(req_ready), 32'(phase == 0));
    chk("mem_rd", 32'(mem_rd), 32'(e_rd));
    chk("mem_wr", 32'(mem_wr), 32'(e_wr));
    chk("resp_valid", 32'(resp_valid), 32'(e_valid));
    chk("resp_rdata", resp_rdata, exp_rdata);
    if (e_valid) chk("resp_err", 32'(resp_err), 32'(m_fault));
    if (e_rd || e_wr) chk("mem_addr", 32'(mem_addr), 32'(m_idx));
    if (e_wr) chk("mem_wdata", mem_wdata,
                  m_ws ? m_wd : f_store(ref_mem[m_idx], m_sz, m_addr[1:0], m_wd));
  end

  int          resp_t [$];
  logic [31:0] resp_d [$];
  always @(negedge clk) begin
    if (resp_valid) begin
      resp_t.push_back(cyc);
      resp_d.push_back(resp_rdata);
    end
  end

  // ---------------- directed request with literal expectations ----------------
  task automatic do_req(input string nm, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input int exp_rdc, input int exp_wrc,
                        input logic [6:0] exp_wa, input logic [31:0] exp_wdat,
                        input logic chk_data, input logic [31:0] exp_data, input logic exp_err);
    int          l, rdc, wrc;
    logic [6:0]  wa;
    logic [31:0] wdat, data;
    logic        err;
    l = 0; rdc = 0; wrc = 0; wa = '0; wdat = '0; data = '0; err = 1'b0;
    @(posedge clk); #2;
    req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    for (int c = 1; c <= 8 && l == 0; c++) begin
      @(negedge clk);
      if (mem_rd && rdc == 0) rdc = c;
      if (mem_wr && wrc == 0) begin
        wrc = c; wa = mem_addr; wdat = mem_wdata;
      end
      if (resp_valid) begin
        l = c; err = resp_err; data = resp_rdata;
      end
    end
    chk({nm, "/latency"}, 32'(l), 32'(exp_lat));
    chk({nm, "/rd_cycle"}, 32'(rdc), 32'(exp_rdc));
    chk({nm, "/wr_cycle"}, 32'(wrc), 32'(exp_wrc));
    chk({nm, "/err"}, 32'(err), 32'(exp_err));
    if (exp_wrc != 0) begin
      chk({nm, "/wr_addr"}, 32'(wa), 32'(exp_wa));
      chk({nm, "/wr_data"}, wdat, exp_wdat);
    end
    if (chk_data) chk({nm, "/rdata"}, data, exp_data);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected one");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      dmem[i]    = $urandom();
      ref_mem[i] = dmem[i];
    end
    dmem[5]    = 32'h8899AABB;
    ref_mem[5] = 32'h8899AABB;

    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst/req_ready", 32'(req_ready), 32'd1);
    chk("rst/resp_valid", 32'(resp_valid), 32'd0);
    chk("rst/resp_err", 32'(resp_err), 32'd0);
    chk("rst/resp_rdata", resp_rdata, 32'd0);
    chk("rst/mem_addr", 32'(mem_addr), 32'd0);
    chk("rst/mem_rd", 32'(mem_rd), 32'd0);
    chk("rst/mem_wr", 32'(mem_wr), 32'd0);
    chk("rst/mem_wdata", mem_wdata, 32'd0);
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst = 1'b0;

    do_req("lb_0x15",  1'b0, 2'd0, 1'b1, 32'h15, 32'h0, 3, 1, 0, 7'd0, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0);
    do_req("lbu_0x15", 1'b0, 2'd0, 1'b0, 32'h15, 32'h0, 3, 1, 0, 7'd0, 32'h0, 1'b1, 32'h000000AA, 1'b0);
    do_req("lh_0x16",  1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 3, 1, 0, 7'd0, 32'h0, 1'b1, 32'hFFFF8899, 1'b0);

    // Sub-word store interrupted by reset while its read is issued.
    @(posedge clk); #2;
    req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h14; req_wdata = 32'hFF;
    req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_rst/mem_rd_drop", 32'(mem_rd), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rmw_rst/no_wr", 32'(mem_wr), 32'd0);
      chk("rmw_rst/no_resp", 32'(resp_valid), 32'd0);
    end
    chk("rmw_rst/req_ready", 32'(req_ready), 32'd1);
    do_req("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 3, 1, 0, 7'd0, 32'h0, 1'b1, 32'h8899AABB, 1'b0);

    do_req("sh_0x16", 1'b1, 2'd1, 1'b0, 32'h16, 32'h00001234, 3, 1, 2, 7'd5, 32'h1234AABB, 1'b0, 32'h0, 1'b0);
    do_req("lw_0x14", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 3, 1, 0, 7'd0, 32'h0, 1'b1, 32'h1234AABB, 1'b0);
    do_req("sw_0x20", 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 2, 0, 1, 7'd8, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    do_req("lw_0x20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 3, 1, 0, 7'd0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    do_req("flt_sw_0x06", 1'b1, 2'd2, 1'b0, 32'h06, 32'h11111111, 1, 0, 0, 7'd0, 32'h0, 1'b1, 32'h0, 1'b1);
    do_req("flt_lh_0x15", 1'b0, 2'd1, 1'b1, 32'h15, 32'h0, 1, 0, 0, 7'd0, 32'h0, 1'b1, 32'h0, 1'b1);
    do_req("flt_size3",   1'b0, 2'd3, 1'b0, 32'h14, 32'h0, 1, 0, 0, 7'd0, 32'h0, 1'b1, 32'h0, 1'b1);

    // Back-to-back loads with req_valid held high.
    begin
      logic        b_we [3];
      logic [1:0]  b_sz [3];
      logic        b_sg [3];
      logic [31:0] b_ad [3];
      logic [31:0] b_ex [3];
      int          k, a_prev;
      b_sz[0] = 2'd2; b_sg[0] = 1'b0; b_ad[0] = 32'h14; b_ex[0] = 32'h1234AABB;
      b_sz[1] = 2'd2; b_sg[1] = 1'b0; b_ad[1] = 32'h20; b_ex[1] = 32'hDEADBEEF;
      b_sz[2] = 2'd0; b_sg[2] = 1'b1; b_ad[2] = 32'h15; b_ex[2] = 32'hFFFFFFAA;
      for (int i = 0; i < 3; i++) b_we[i] = 1'b0;
      @(posedge clk); #2;
      resp_t.delete();
      resp_d.delete();
      k = 0;
      a_prev = acc_cnt;
      req_we = b_we[0]; req_size = b_sz[0]; req_signed = b_sg[0]; req_addr = b_ad[0];
      req_valid = 1'b1;
      for (int c = 0; c < 40 && k < 3; c++) begin
        @(posedge clk); #2;
        if (acc_cnt != a_prev) begin
          a_prev = acc_cnt;
          k++;
          if (k < 3) begin
            req_we = b_we[k]; req_size = b_sz[k]; req_signed = b_sg[k]; req_addr = b_ad[k];
          end else begin
            req_valid = 1'b0;
          end
        end
      end
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      if (resp_t.size() != 3) begin
        fail_now("b2b/resp_count");
      end else begin
        for (int i = 0; i < 3; i++) chk("b2b/rdata", resp_d[i], b_ex[i]);
        chk("b2b/spacing01", 32'(resp_t[1] - resp_t[0]), 32'd4);
        chk("b2b/spacing12", 32'(resp_t[2] - resp_t[1]), 32'd4);
      end
    end

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 80; i++) begin
      int unsigned r, gap;
      int          a0;
      logic [31:0] idx, off;
      r   = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      off = $urandom_range(0, 3);
      req_we     = $urandom_range(0, 1) == 1;
      req_size   = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      req_signed = $urandom_range(0, 1) == 1;
      req_addr   = ($urandom() << 9) | (idx << 2) | off;
      req_wdata  = $urandom();
      req_valid  = 1'b1;
      a0 = acc_cnt;
      for (int c = 0; c < 12 && acc_cnt == a0; c++) begin
        @(posedge clk); #2;
      end
      if (acc_cnt == a0) fail_now("rand/accept");
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        req_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk); #2;
        end
      end
    end
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
